// File: rtl/fetch_unit.sv
// fetch_unit: decoupled RV32I fetch engine with a prefetch FIFO, in-order memory responses and redirect flush
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            imreq_out,
    output logic [XLEN-1:0] imaddr_out,
    input  logic            imgnt_in,
    input  logic            imrvalid_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            instr_valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    input  logic            instr_ready_in,
    output logic            misaligned_instr_out,
    output logic            busy_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0] outstanding, drop, fifo_count;
    logic [AW-1:0] wr_ptr, rd_ptr, tq_wr, tq_rd;
    logic [XLEN-1:0] fifo_pc [DEPTH];
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] tag_q [DEPTH];
    logic [CW:0] credit;
    logic grant, dropping, push, pop;

    always_comb begin
        state_nxt = state;
        if (redirect_in) state_nxt = (redirect_pc_in[1:0] != 2'b00) ? HALT : RUN;
    end

    // Outstanding includes responses still owed to a flushed stream, so drops consume credit
    assign credit = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imreq_out = rst_in & (state == RUN) & !redirect_in & (credit < (CW+1)'(DEPTH));
    assign imaddr_out = fetch_pc;
    assign grant = imreq_out & imgnt_in;
    assign dropping = drop != '0;
    assign push = imrvalid_in & !dropping & !redirect_in;
    assign instr_valid_out = fifo_count != '0;
    assign pop = instr_valid_out & instr_ready_in;
    assign instr_out = instr_valid_out ? fifo_instr[rd_ptr] : '0;
    assign pc_out = instr_valid_out ? fifo_pc[rd_ptr] : '0;
    assign misaligned_instr_out = state == HALT;
    assign busy_out = (outstanding != '0) | dropping;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tq_wr       <= '0;
            tq_rd       <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding + CW'(grant) - CW'(imrvalid_in);
            if (redirect_in) begin
                fetch_pc   <= {redirect_pc_in[XLEN-1:2], 2'b00};
                drop       <= outstanding - CW'(imrvalid_in);
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                tq_wr      <= '0;
                tq_rd      <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    tq_wr    <= tq_wr + AW'(1);
                end
                if (imrvalid_in && dropping) drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    tq_rd  <= tq_rd + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (grant) tag_q[tq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= tag_q[tq_rd];
            fifo_instr[wr_ptr] <= instr_in;
        end
    end

    assert property (@(posedge clk_in) disable iff (!rst_in) push |-> (fifo_count != CW'(DEPTH) || pop));
    assert property (@(posedge clk_in) disable iff (!rst_in) imrvalid_in |-> (outstanding != '0));
endmodule
